// File: rtl/friscv_dcache_bridge.sv
// Data-side bridge from the memfy load/store unit to the wide AXI memory bus.
// Tracks outstanding traffic, steers lanes, guards read-after-write and drains on flush.
module friscv_dcache_bridge #(
    parameter int XLEN        = 32,
    parameter int AXI_ADDR_W  = 32,
    parameter int AXI_ID_W    = 8,
    parameter int AXI_DATA_W  = 128,
    parameter int AXI_ID_MASK = 'h40,
    parameter int OSTDREQ_NUM = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    srst,
    input  logic                    flush_req,
    output logic                    flush_ack,
    input  logic                    memfy_awvalid,
    output logic                    memfy_awready,
    input  logic [AXI_ADDR_W-1:0]   memfy_awaddr,
    input  logic [AXI_ID_W-1:0]     memfy_awid,
    input  logic                    memfy_wvalid,
    output logic                    memfy_wready,
    input  logic [XLEN-1:0]         memfy_wdata,
    input  logic [XLEN/8-1:0]       memfy_wstrb,
    output logic                    memfy_bvalid,
    input  logic                    memfy_bready,
    output logic [AXI_ID_W-1:0]     memfy_bid,
    output logic [1:0]              memfy_bresp,
    input  logic                    memfy_arvalid,
    output logic                    memfy_arready,
    input  logic [AXI_ADDR_W-1:0]   memfy_araddr,
    input  logic [AXI_ID_W-1:0]     memfy_arid,
    output logic                    memfy_rvalid,
    input  logic                    memfy_rready,
    output logic [AXI_ID_W-1:0]     memfy_rid,
    output logic [1:0]              memfy_rresp,
    output logic [XLEN-1:0]         memfy_rdata,
    output logic                    mem_awvalid,
    input  logic                    mem_awready,
    output logic [AXI_ADDR_W-1:0]   mem_awaddr,
    output logic [AXI_ID_W-1:0]     mem_awid,
    output logic                    mem_wvalid,
    input  logic                    mem_wready,
    output logic [AXI_DATA_W-1:0]   mem_wdata,
    output logic [AXI_DATA_W/8-1:0] mem_wstrb,
    input  logic                    mem_bvalid,
    output logic                    mem_bready,
    input  logic [AXI_ID_W-1:0]     mem_bid,
    input  logic [1:0]              mem_bresp,
    output logic                    mem_arvalid,
    input  logic                    mem_arready,
    output logic [AXI_ADDR_W-1:0]   mem_araddr,
    output logic [AXI_ID_W-1:0]     mem_arid,
    input  logic                    mem_rvalid,
    output logic                    mem_rready,
    input  logic [AXI_ID_W-1:0]     mem_rid,
    input  logic [1:0]              mem_rresp,
    input  logic [AXI_DATA_W-1:0]   mem_rdata,
    input  logic                    mem_rlast
);

    localparam int SCALE  = AXI_DATA_W / XLEN;
    localparam int LW     = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int BOFF   = $clog2(XLEN / 8);
    localparam int LOFF   = $clog2(AXI_DATA_W / 8);
    localparam int LINE_W = AXI_ADDR_W - LOFF;
    localparam int PW     = $clog2(OSTDREQ_NUM);
    localparam int SW     = AXI_DATA_W / 8;
    localparam logic [PW-1:0] P1 = 1;
    localparam logic [PW:0]   C1 = 1;
    localparam logic [PW:0]   CN = OSTDREQ_NUM;

    typedef enum logic [1:0] {IDLE, DRAIN, ACK} fl_t;

    function automatic logic [LW-1:0] lane_of(input logic [AXI_ADDR_W-1:0] a);
        return LW'((a >> BOFF) & AXI_ADDR_W'(SCALE - 1));
    endfunction

    function automatic logic [LINE_W-1:0] line_of(input logic [AXI_ADDR_W-1:0] a);
        return LINE_W'(a >> LOFF);
    endfunction

    fl_t                state, state_nxt;
    logic [LINE_W-1:0]  wline [OSTDREQ_NUM];
    logic [LW-1:0]      wlane [OSTDREQ_NUM];
    logic [LW-1:0]      rlane [OSTDREQ_NUM];
    logic [OSTDREQ_NUM-1:0] wvld;
    logic [PW-1:0]      aw_ptr, w_ptr, b_ptr, r_wp, r_rp;
    logic [PW:0]        wcnt, wcnt_nxt, rcnt, rcnt_nxt, wpend, wpend_nxt;
    logic               run, draining, hit;
    logic               aw_ok, w_ok, ar_ok;
    logic               aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [LINE_W-1:0]  ar_line;
    logic [LW-1:0]      w_lane, r_lane;

    assign run      = aresetn & ~srst;
    assign draining = (state != IDLE);
    assign ar_line  = line_of(memfy_araddr);
    assign w_lane   = wlane[w_ptr];
    assign r_lane   = rlane[r_rp];

    assign aw_ok = run & (wcnt != CN) & ~draining;
    assign w_ok  = run & (wpend != '0);
    assign ar_ok = run & (rcnt != CN) & ~hit & ~draining;

    assign aw_hs = memfy_awvalid & mem_awready & aw_ok;
    assign w_hs  = memfy_wvalid & mem_wready & w_ok;
    assign b_hs  = mem_bvalid & memfy_bready & run;
    assign ar_hs = memfy_arvalid & mem_arready & ar_ok;
    assign r_hs  = mem_rvalid & memfy_rready & mem_rlast & run;

    assign mem_awvalid   = memfy_awvalid & aw_ok;
    assign memfy_awready = mem_awready & aw_ok;
    assign mem_awaddr    = memfy_awaddr;
    assign mem_awid      = memfy_awid | AXI_ID_W'(AXI_ID_MASK);

    assign mem_wvalid   = memfy_wvalid & w_ok;
    assign memfy_wready = mem_wready & w_ok;
    assign mem_wdata    = {SCALE{memfy_wdata}};
    assign mem_wstrb    = SW'(memfy_wstrb) << (int'(w_lane) * (XLEN / 8));

    assign memfy_bvalid = mem_bvalid & run;
    assign mem_bready   = memfy_bready & run;
    assign memfy_bid    = mem_bid;
    assign memfy_bresp  = mem_bresp;

    assign mem_arvalid   = memfy_arvalid & ar_ok;
    assign memfy_arready = mem_arready & ar_ok;
    assign mem_araddr    = memfy_araddr;
    assign mem_arid      = memfy_arid | AXI_ID_W'(AXI_ID_MASK);

    assign memfy_rvalid = mem_rvalid & run;
    assign mem_rready   = memfy_rready & run;
    assign memfy_rid    = mem_rid;
    assign memfy_rresp  = mem_rresp;
    assign memfy_rdata  = mem_rdata[int'(r_lane) * XLEN +: XLEN];

    assign flush_ack = run & (state == ACK);

    // Read-after-write guard: match the AR line against every live write and the incoming AW
    always_comb begin
        hit = aw_hs && (line_of(memfy_awaddr) == ar_line);
        for (int i = 0; i < OSTDREQ_NUM; i++)
            if (wvld[i] && (wline[i] == ar_line))
                hit = 1'b1;
    end

    // Next occupancy counts; a push and pop in one cycle cancel out
    always_comb begin
        wcnt_nxt = wcnt;
        if (aw_hs && !b_hs) wcnt_nxt = wcnt + C1;
        else if (!aw_hs && b_hs) wcnt_nxt = wcnt - C1;
        rcnt_nxt = rcnt;
        if (ar_hs && !r_hs) rcnt_nxt = rcnt + C1;
        else if (!ar_hs && r_hs) rcnt_nxt = rcnt - C1;
        wpend_nxt = wpend;
        if (aw_hs && !w_hs) wpend_nxt = wpend + C1;
        else if (!aw_hs && w_hs) wpend_nxt = wpend - C1;
    end

    // Flush sequencing: block new requests, wait for both trackers to empty, then ack
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (flush_req) state_nxt = DRAIN;
            DRAIN:   if (wcnt_nxt == '0 && rcnt_nxt == '0) state_nxt = ACK;
            ACK:     state_nxt = flush_req ? DRAIN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Tracking state, pointers and flush state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            wvld   <= '0;
            wcnt   <= '0;
            rcnt   <= '0;
            wpend  <= '0;
            aw_ptr <= '0;
            w_ptr  <= '0;
            b_ptr  <= '0;
            r_wp   <= '0;
            r_rp   <= '0;
        end else if (srst) begin
            state  <= IDLE;
            wvld   <= '0;
            wcnt   <= '0;
            rcnt   <= '0;
            wpend  <= '0;
            aw_ptr <= '0;
            w_ptr  <= '0;
            b_ptr  <= '0;
            r_wp   <= '0;
            r_rp   <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            rcnt  <= rcnt_nxt;
            wpend <= wpend_nxt;
            if (b_hs) begin
                wvld[b_ptr] <= 1'b0;
                b_ptr       <= b_ptr + P1;
            end
            if (aw_hs) begin
                wvld[aw_ptr] <= 1'b1;
                aw_ptr       <= aw_ptr + P1;
            end
            if (w_hs) w_ptr <= w_ptr + P1;
            if (ar_hs) r_wp <= r_wp + P1;
            if (r_hs) r_rp <= r_rp + P1;
        end
    end

    // Tracker payload storage; validity is carried by the counters and wvld
    always_ff @(posedge aclk) begin
        if (aw_hs) begin
            wline[aw_ptr] <= line_of(memfy_awaddr);
            wlane[aw_ptr] <= lane_of(memfy_awaddr);
        end
        if (ar_hs) rlane[r_wp] <= lane_of(memfy_araddr);
    end

endmodule

// File: tb/tb_friscv_dcache_bridge.sv
// Directed bench for friscv_dcache_bridge with a read-data scoreboard.
// Covers lane steering, RAW guard, full, flush drain, resets and error forwarding.
module tb_friscv_dcache_bridge;

    logic         aclk;
    logic         aresetn, srst, flush_req, flush_ack;
    logic         memfy_awvalid, memfy_awready;
    logic [31:0]  memfy_awaddr;
    logic [7:0]   memfy_awid;
    logic         memfy_wvalid, memfy_wready;
    logic [31:0]  memfy_wdata;
    logic [3:0]   memfy_wstrb;
    logic         memfy_bvalid, memfy_bready;
    logic [7:0]   memfy_bid;
    logic [1:0]   memfy_bresp;
    logic         memfy_arvalid, memfy_arready;
    logic [31:0]  memfy_araddr;
    logic [7:0]   memfy_arid;
    logic         memfy_rvalid, memfy_rready;
    logic [7:0]   memfy_rid;
    logic [1:0]   memfy_rresp;
    logic [31:0]  memfy_rdata;
    logic         mem_awvalid, mem_awready;
    logic [31:0]  mem_awaddr;
    logic [7:0]   mem_awid;
    logic         mem_wvalid, mem_wready;
    logic [127:0] mem_wdata;
    logic [15:0]  mem_wstrb;
    logic         mem_bvalid, mem_bready;
    logic [7:0]   mem_bid;
    logic [1:0]   mem_bresp;
    logic         mem_arvalid, mem_arready;
    logic [31:0]  mem_araddr;
    logic [7:0]   mem_arid;
    logic         mem_rvalid, mem_rready;
    logic [7:0]   mem_rid;
    logic [1:0]   mem_rresp;
    logic [127:0] mem_rdata;
    logic         mem_rlast;

    int errors = 0;
    int checks = 0;
    int acks;
    logic [31:0] exp_q[$];

    localparam logic [127:0] RPAT =
        128'hC3C3C3C3_DEADBEEF_A1A1A1A1_90909090;

    friscv_dcache_bridge dut (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .flush_req(flush_req), .flush_ack(flush_ack),
        .memfy_awvalid(memfy_awvalid), .memfy_awready(memfy_awready),
        .memfy_awaddr(memfy_awaddr), .memfy_awid(memfy_awid),
        .memfy_wvalid(memfy_wvalid), .memfy_wready(memfy_wready),
        .memfy_wdata(memfy_wdata), .memfy_wstrb(memfy_wstrb),
        .memfy_bvalid(memfy_bvalid), .memfy_bready(memfy_bready),
        .memfy_bid(memfy_bid), .memfy_bresp(memfy_bresp),
        .memfy_arvalid(memfy_arvalid), .memfy_arready(memfy_arready),
        .memfy_araddr(memfy_araddr), .memfy_arid(memfy_arid),
        .memfy_rvalid(memfy_rvalid), .memfy_rready(memfy_rready),
        .memfy_rid(memfy_rid), .memfy_rresp(memfy_rresp),
        .memfy_rdata(memfy_rdata),
        .mem_awvalid(mem_awvalid), .mem_awready(mem_awready),
        .mem_awaddr(mem_awaddr), .mem_awid(mem_awid),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_bvalid(mem_bvalid), .mem_bready(mem_bready),
        .mem_bid(mem_bid), .mem_bresp(mem_bresp),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
        .mem_araddr(mem_araddr), .mem_arid(mem_arid),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
        .mem_rid(mem_rid), .mem_rresp(mem_rresp),
        .mem_rdata(mem_rdata), .mem_rlast(mem_rlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        case (a[3:2])
            2'd0: return 32'h90909090;
            2'd1: return 32'hA1A1A1A1;
            2'd2: return 32'hDEADBEEF;
            default: return 32'hC3C3C3C3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic r_beat(input logic [1:0] resp, input logic [7:0] id);
        logic [31:0] e;
        mem_rvalid   = 1'b1;
        mem_rlast    = 1'b1;
        mem_rdata    = RPAT;
        mem_rresp    = resp;
        mem_rid      = id;
        memfy_rready = 1'b1;
        #1;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        chk("r_data", memfy_rdata, e);
        chk("r_valid", memfy_rvalid, 1'b1);
        chk("r_resp", memfy_rresp, resp);
        chk("r_id", memfy_rid, id);
    endtask

    task automatic r_end();
        mem_rvalid   = 1'b0;
        mem_rlast    = 1'b0;
        memfy_rready = 1'b0;
    endtask

    task automatic ar_issue(input logic [31:0] a, input string tag);
        memfy_arvalid = 1'b1;
        memfy_araddr  = a;
        exp_q.push_back(word_of(a));
        #1;
        chk(tag, mem_arvalid, 1'b1);
        tick();
        memfy_arvalid = 1'b0;
    endtask

    task automatic aw_issue(input logic [31:0] a, input string tag);
        memfy_awvalid = 1'b1;
        memfy_awaddr  = a;
        #1;
        chk(tag, memfy_awready, 1'b1);
        tick();
        memfy_awvalid = 1'b0;
    endtask

    task automatic w_beat();
        memfy_wvalid = 1'b1;
        #1;
        chk("w_pass", mem_wvalid, 1'b1);
        tick();
        memfy_wvalid = 1'b0;
    endtask

    task automatic b_beat();
        mem_bvalid   = 1'b1;
        memfy_bready = 1'b1;
        tick();
        mem_bvalid   = 1'b0;
        memfy_bready = 1'b0;
    endtask

    initial begin
        aresetn = 0; srst = 0; flush_req = 0;
        memfy_awvalid = 1; memfy_awaddr = 0; memfy_awid = 0;
        memfy_wvalid = 0; memfy_wdata = 0; memfy_wstrb = 0;
        memfy_bready = 0;
        memfy_arvalid = 1; memfy_araddr = 0; memfy_arid = 0;
        memfy_rready = 0;
        mem_awready = 1; mem_wready = 1; mem_arready = 1;
        mem_bvalid = 0; mem_bid = 0; mem_bresp = 0;
        mem_rvalid = 0; mem_rid = 0; mem_rresp = 0;
        mem_rdata = 0; mem_rlast = 0;
        #3;
        chk("rst_awready", memfy_awready, 1'b0);
        chk("rst_arready", memfy_arready, 1'b0);
        chk("rst_awvalid", mem_awvalid, 1'b0);
        chk("rst_ack", flush_ack, 1'b0);
        memfy_awvalid = 0;
        memfy_arvalid = 0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1;
        tick();

        // single write then read
        memfy_awvalid = 1; memfy_awaddr = 32'h1008; memfy_awid = 8'h05;
        memfy_wvalid = 1; memfy_wdata = 32'hDEADBEEF; memfy_wstrb = 4'hF;
        #1;
        chk("aw_valid", mem_awvalid, 1'b1);
        chk("aw_id", mem_awid, 8'h45);
        chk("aw_ready", memfy_awready, 1'b1);
        chk("w_before_aw", mem_wvalid, 1'b0);
        tick();
        memfy_awvalid = 0;
        #1;
        chk("w_valid", mem_wvalid, 1'b1);
        chk("w_strb", mem_wstrb, 16'h0F00);
        chk("w_data", mem_wdata, {4{32'hDEADBEEF}});
        tick();
        memfy_wvalid = 0;
        mem_bvalid = 1; mem_bid = 8'h45; mem_bresp = 2'b10; memfy_bready = 1;
        #1;
        chk("b_valid", memfy_bvalid, 1'b1);
        chk("b_id", memfy_bid, 8'h45);
        chk("b_resp_err", memfy_bresp, 2'b10);
        tick();
        mem_bvalid = 0; memfy_bready = 0; mem_bresp = 0;
        memfy_arid = 8'h03;
        memfy_arvalid = 1; memfy_araddr = 32'h1008;
        #1;
        chk("ar_id", mem_arid, 8'h43);
        ar_issue(32'h1008, "ar_1008");
        r_beat(2'b00, 8'h43);
        tick();
        r_end();

        // RAW guard
        aw_issue(32'h2004, "aw_2004");
        ar_issue(32'h2010, "raw_other_line");
        memfy_arvalid = 1; memfy_araddr = 32'h200C;
        #1;
        chk("raw_block", mem_arvalid, 1'b0);
        chk("raw_block_rdy", memfy_arready, 1'b0);
        tick();
        mem_bvalid = 1; memfy_bready = 1;
        #1;
        chk("raw_b_same_cycle", mem_arvalid, 1'b0);
        tick();
        mem_bvalid = 0; memfy_bready = 0;
        ar_issue(32'h200C, "raw_after_b");
        memfy_wvalid = 1;
        #1;
        chk("w_strb_lane1", mem_wstrb, 16'h00F0);
        tick();
        memfy_wvalid = 0;
        r_beat(2'b00, 8'h43);
        tick();
        r_beat(2'b00, 8'h43);
        tick();
        r_end();
        memfy_awvalid = 1; memfy_awaddr = 32'h3000;
        memfy_arvalid = 1; memfy_araddr = 32'h3008;
        #1;
        chk("raw_aw_same_cycle", mem_arvalid, 1'b0);
        chk("raw_aw_same_aw", mem_awvalid, 1'b1);
        tick();
        memfy_awvalid = 0; memfy_arvalid = 0;
        w_beat();
        b_beat();

        // full
        for (int i = 0; i < 4; i++) begin
            aw_issue(32'h4000 + 32'(i * 16), "full_fill");
            w_beat();
        end
        memfy_awvalid = 1; memfy_awaddr = 32'h4040;
        #1;
        chk("full_refuse", memfy_awready, 1'b0);
        chk("full_awvalid", mem_awvalid, 1'b0);
        tick();
        mem_bvalid = 1; memfy_bready = 1;
        #1;
        chk("full_b_same", memfy_awready, 1'b0);
        tick();
        mem_bvalid = 0; memfy_bready = 0;
        #1;
        chk("full_after_b", memfy_awready, 1'b1);
        tick();
        memfy_awvalid = 0;
        w_beat();
        repeat (4) b_beat();

        // flush drain
        ar_issue(32'h5000, "fl_ar0");
        ar_issue(32'h5004, "fl_ar1");
        flush_req = 1;
        tick();
        memfy_arvalid = 1; memfy_araddr = 32'h6000;
        #1;
        chk("fl_arready", memfy_arready, 1'b0);
        chk("fl_arvalid", mem_arvalid, 1'b0);
        r_beat(2'b00, 8'h11);
        chk("fl_no_ack0", flush_ack, 1'b0);
        tick();
        r_end();
        #1;
        chk("fl_no_ack1", flush_ack, 1'b0);
        chk("fl_arready1", memfy_arready, 1'b0);
        r_beat(2'b00, 8'h12);
        chk("fl_no_ack2", flush_ack, 1'b0);
        tick();
        r_end();
        #1;
        chk("fl_ack", flush_ack, 1'b1);
        chk("fl_arready2", memfy_arready, 1'b0);
        flush_req = 0;
        memfy_arvalid = 0;
        acks = 0;
        repeat (4) begin
            tick();
            if (flush_ack) acks++;
        end
        chk("fl_once", acks, 0);

        // reset mid-flight
        aw_issue(32'h7000, "rst_aw0");
        aw_issue(32'h7010, "rst_aw1");
        aw_issue(32'h7020, "rst_aw2");
        mem_bvalid = 1; memfy_bready = 1; mem_rvalid = 1; memfy_rready = 1;
        memfy_awvalid = 1; memfy_awaddr = 32'h7030;
        memfy_arvalid = 1; memfy_araddr = 32'h9000; memfy_wvalid = 1;
        #1;
        aresetn = 0;
        #1;
        chk("arst_awready", memfy_awready, 1'b0);
        chk("arst_awvalid", mem_awvalid, 1'b0);
        chk("arst_arvalid", mem_arvalid, 1'b0);
        chk("arst_wvalid", mem_wvalid, 1'b0);
        chk("arst_bvalid", memfy_bvalid, 1'b0);
        chk("arst_rvalid", memfy_rvalid, 1'b0);
        chk("arst_bready", mem_bready, 1'b0);
        chk("arst_rready", mem_rready, 1'b0);
        mem_bvalid = 0; memfy_bready = 0; mem_rvalid = 0; memfy_rready = 0;
        memfy_awvalid = 0; memfy_arvalid = 0;
        tick();
        aresetn = 1;
        #1;
        chk("arst_wpend", mem_wvalid, 1'b0);
        memfy_wvalid = 0;
        for (int i = 0; i < 4; i++)
            aw_issue(32'hA000 + 32'(i * 16), "post_rst_aw");
        memfy_awvalid = 1; memfy_awaddr = 32'hA040;
        #1;
        chk("post_rst_cnt", memfy_awready, 1'b0);
        memfy_awvalid = 0;
        tick();
        srst = 1;
        tick();
        memfy_arvalid = 1; memfy_araddr = 32'hB000;
        #1;
        chk("srst_arready", memfy_arready, 1'b0);
        memfy_arvalid = 0;
        srst = 0;
        memfy_awvalid = 1; memfy_awaddr = 32'hB000;
        #1;
        chk("srst_clears", memfy_awready, 1'b1);
        memfy_awvalid = 0;
        tick();

        // error forwarding
        ar_issue(32'h8008, "err_ar0");
        ar_issue(32'h800C, "err_ar1");
        r_beat(2'b10, 8'h47);
        tick();
        r_beat(2'b00, 8'h48);
        tick();
        r_end();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/friscv_dcache_bridge.md
# friscv_dcache_bridge

Data-side bridge between the memfy load/store unit (XLEN-wide, AXI4-lite-like) and the AXI4 central-memory interconnect (AXI_DATA_W-wide). It replaces the stateless data pass-through with outstanding-request tracking, lane steering in both directions and a read-after-write hazard guard. Its FENCE flush handshake is real: the acknowledge is given only once all traffic has drained. It sits between friscv_memfy and the AXI crossbar.

## Interface
Parameters:
- XLEN, 32, memfy data width.
- AXI_ADDR_W, 32, address width, both sides.
- AXI_ID_W, 8, ID width.
- AXI_DATA_W, 128, memory data width; must be a multiple of XLEN, with SCALE = AXI_DATA_W/XLEN ≥ 1.
- AXI_ID_MASK, 'h40, ORed into every downstream AWID/ARID.
- OSTDREQ_NUM, 4, maximum outstanding writes and maximum outstanding reads, each; must be a power of 2.

Ports:
- aclk in 1: clock.
- aresetn in 1: asynchronous active-low reset.
- srst in 1: synchronous reset, active high; same effect as aresetn.
- flush_req in 1: drain request, level.
- flush_ack out 1: one-cycle pulse when drained.
- memfy_awvalid/awready in/out 1: write address handshake. memfy_awaddr in AXI_ADDR_W. memfy_awid in AXI_ID_W.
- memfy_wvalid/wready in/out 1: write data handshake. memfy_wdata in XLEN. memfy_wstrb in XLEN/8.
- memfy_bvalid/bready out/in 1: write response handshake. memfy_bid out AXI_ID_W. memfy_bresp out 2.
- memfy_arvalid/arready in/out 1: read address handshake. memfy_araddr in AXI_ADDR_W. memfy_arid in AXI_ID_W.
- memfy_rvalid/rready out/in 1: read data handshake. memfy_rid out AXI_ID_W. memfy_rresp out 2. memfy_rdata out XLEN.
- mem_aw*, mem_w*, mem_b*, mem_ar*, mem_r*: same signal set as the memfy side, with direction reversed. Data is AXI_DATA_W wide, strobes AXI_DATA_W/8.
- Constant AXI sidebands are tied at top level by the instantiating wrapper: len = 0, size = log2(XLEN/8), burst = INCR, all others 0.

## Operation
- Write tracking FIFO, depth OSTDREQ_NUM, holds {line address = awaddr[AXI_ADDR_W-1:log2(AXI_DATA_W/8)], lane = awaddr[log2(XLEN/8)+:log2(SCALE)]}.
  - Push on the AW handshake.
  - Lane pointer (W side) advances on the W handshake.
  - Entry retires on the B handshake, oldest first. Downstream must return B responses in issue order.
- Read tracking FIFO, depth OSTDREQ_NUM, holds the lane. Push on the AR handshake; pop on an R handshake with rlast = 1.
- AW gating: mem_awvalid = memfy_awvalid & !wfull & !draining. memfy_awready = mem_awready under the same gate.
- W gating: a W beat passes only when an AW exists with no W beat yet sent.
  - mem_wvalid = memfy_wvalid & w_pending.
  - mem_wdata = memfy_wdata replicated SCALE times.
  - mem_wstrb = memfy_wstrb placed at the lane, zeros elsewhere.
- RAW guard: AR is blocked while any valid write-FIFO entry (sent or unsent) has a line address equal to memfy_araddr's line address. Comparison is against all OSTDREQ_NUM entries in parallel.
  - mem_arvalid = memfy_arvalid & !rfull & !hit & !draining.
- R steering: memfy_rdata = mem_rdata[lane*XLEN +: XLEN], using the lane at the read FIFO head. rvalid, rid, rresp and rready pass through.
- B channel passes through unchanged.
- IDs: mem_awid = memfy_awid | AXI_ID_MASK; mem_arid = memfy_arid | AXI_ID_MASK.
- Flush FSM has three states:
  - IDLE → DRAIN when flush_req = 1. While draining, new AW/AR are blocked.
  - DRAIN → ACK when both FIFOs are empty.
  - ACK: flush_ack = 1 for one cycle, then go to IDLE. If flush_req is still high, re-enter DRAIN; the next ack comes no earlier than 2 cycles later.
- Error status: any B or R response with resp[1] = 1 is forwarded unchanged. No local state is kept.

## Timing
- Zero-cycle combinational forwarding on all channels; no added latency.
- Reset (aresetn low or srst high):
  - Both FIFOs empty, FSM in IDLE.
  - flush_ack = 0, all valids = 0, all readies = 0.
- Reset taken mid-transaction discards all tracking state. The upstream side must be reset together with this block.
- Full: when a FIFO holds OSTDREQ_NUM entries, the corresponding ready is 0. If a retirement and an acceptance happen in the same cycle while full, the acceptance is still refused that cycle; ready is based on the registered count.
- Simultaneous push and pop on one FIFO leaves the count unchanged.
- Simultaneous AW handshake and AR to the same line in the same cycle: the hit compare also includes the incoming AW, so the AR is blocked.
- A B retirement and a matching AR in the same cycle: the AR stays blocked that cycle and proceeds the next cycle.
- Pointers wrap modulo OSTDREQ_NUM.

## Test plan
- Single write then read, SCALE = 4, awaddr = 0x1008, wdata = 0xDEADBEEF, wstrb = 0xF:
  - mem_wstrb = 0x0F00, wdata replicated.
  - Read with araddr = 0x1008 and mem_rdata lane 2 = 0xDEADBEEF gives memfy_rdata = 0xDEADBEEF.
  - mem_awid = memfy_awid | 0x40.
- RAW guard: AW to 0x2004 accepted with bready held low; AR to 0x200C (same line) is stalled with mem_arvalid = 0. After the B handshake, the AR issues the next cycle. An AR to 0x2010 issues immediately.
- Full: 4 AWs accepted with no B returned; the 5th sees memfy_awready = 0. One B handshake raises awready the cycle after.
- Flush: 2 reads outstanding when flush_req rises. arready goes to 0 and stays 0. flush_ack pulses exactly once, 1 cycle after the last rlast handshake.
- Reset mid-flight: assert aresetn low with 3 writes outstanding. All outputs go to 0 asynchronously. After release, an AW is accepted and the FIFO count is 1.
- Error forwarding: mem_rresp = 2'b10 appears on memfy_rresp in the same cycle with the correct lane data; tracking pops normally.
